// File: rtl/mod_div_iter.sv
// mod_div_iter: iterative modular divider r = a * b^-1 mod P by binary extended Euclid.
// Optional MODDIV_ERR_EN adds the err port, input range checks and an abort flag.
module mod_div_iter #(
    parameter int DATAWIDTH = 8,
    parameter logic [DATAWIDTH-1:0] P = DATAWIDTH'(251)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
`ifdef MODDIV_ERR_EN
    output logic                 err,
`endif
    output logic [DATAWIDTH-1:0] r
);
    localparam int CW = $clog2(4 * DATAWIDTH + 1);
    localparam logic [CW-1:0] MAX_STEPS = CW'(4 * DATAWIDTH);
    localparam logic [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t state, state_n;
    logic [DATAWIDTH-1:0] u, v, x1, x2, u_n, v_n, x1_n, x2_n, r_n;
    logic [CW-1:0] cnt, cnt_n;
    logic bad;
`ifdef MODDIV_ERR_EN
    logic err_n;
`endif

    // Halve modulo P: an odd residue gets P added first so the sum is even.
    function automatic logic [DATAWIDTH-1:0] half(input logic [DATAWIDTH-1:0] x);
        logic [DATAWIDTH:0] s;
        s = {1'b0, x} + {1'b0, P};
        return x[0] ? s[DATAWIDTH:1] : x >> 1;
    endfunction

    // Subtract modulo P, wrapping a borrow back into [0,P).
    function automatic logic [DATAWIDTH-1:0] msub(input logic [DATAWIDTH-1:0] x, input logic [DATAWIDTH-1:0] y);
        logic [DATAWIDTH:0] s;
        s = {1'b0, x} + {1'b0, P} - {1'b0, y};
        return x >= y ? x - y : s[DATAWIDTH-1:0];
    endfunction

`ifdef MODDIV_ERR_EN
    assign bad = (b == '0) || (a >= P) || (b >= P);
`else
    assign bad = (b == '0);
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // State register and datapath registers, cleared by synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            u     <= '0;
            v     <= '0;
            x1    <= '0;
            x2    <= '0;
            cnt   <= '0;
            r     <= '0;
`ifdef MODDIV_ERR_EN
            err   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            u     <= u_n;
            v     <= v_n;
            x1    <= x1_n;
            x2    <= x2_n;
            cnt   <= cnt_n;
            r     <= r_n;
`ifdef MODDIV_ERR_EN
            err   <= err_n;
`endif
        end
    end

    // Next-state logic: accept, one Euclid step per ITER cycle, hold result until taken.
    always_comb begin
        state_n = state;
        u_n     = u;
        v_n     = v;
        x1_n    = x1;
        x2_n    = x2;
        cnt_n   = cnt;
        r_n     = r;
`ifdef MODDIV_ERR_EN
        err_n   = err;
`endif
        case (state)
            IDLE: if (in_valid) begin
                u_n     = b;
                v_n     = P;
                x1_n    = a;
                x2_n    = '0;
                cnt_n   = '0;
                r_n     = '0;
`ifdef MODDIV_ERR_EN
                err_n   = bad;
`endif
                state_n = bad ? DONE : ITER;
            end
            ITER: begin
                cnt_n = cnt + CW'(1);
                if (u == ONE) begin
                    r_n     = x1;
                    state_n = DONE;
                end else if (v == ONE) begin
                    r_n     = x2;
                    state_n = DONE;
                end else if (cnt == MAX_STEPS) begin
                    r_n     = '0;
`ifdef MODDIV_ERR_EN
                    err_n   = 1'b1;
`endif
                    state_n = DONE;
                end else if (!u[0]) begin
                    u_n  = u >> 1;
                    x1_n = half(x1);
                end else if (!v[0]) begin
                    v_n  = v >> 1;
                    x2_n = half(x2);
                end else if (u >= v) begin
                    u_n  = u - v;
                    x1_n = msub(x1, x2);
                end else begin
                    v_n  = v - u;
                    x2_n = msub(x2, x1);
                end
            end
            DONE: if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mod_div_iter.sv
// tb_mod_div_iter: directed and random checks of mod_div_iter against a Fermat-inverse model.
module tb_mod_div_iter;
    localparam int DW = 8;
    localparam int P = 251;
    localparam int LAT_MAX = 4 * DW + 2;

    logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic [DW-1:0] a = 0, b = 0;
    logic in_ready, out_valid;
    logic [DW-1:0] r;
`ifdef MODDIV_ERR_EN
    logic err;
`endif
    int checks = 0, errors = 0;
    int exp_r = 0;
    int exp_err = 0;
    int got, lat;

    always #5 clk = ~clk;

    mod_div_iter #(.DATAWIDTH(DW), .P(DW'(P))) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
`ifdef MODDIV_ERR_EN
        .err(err),
`endif
        .r(r)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // a * b^(P-2) mod P; zero for operands that are flagged or have no inverse.
    function automatic int model(input int x, input int y);
        longint res = 1, base = y, e = P - 2;
        if (y == 0 || x >= P || y >= P) return 0;
        while (e > 0) begin
            if (e[0]) res = res * base % P;
            base = base * base % P;
            e = e >> 1;
        end
        return int'(longint'(x) * res % P);
    endfunction

    // Every cycle a result is presented, it must equal the model and the input side must be closed.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("r_vs_model", int'(r), exp_r);
            check("in_ready_in_done", int'(in_ready), 0);
`ifdef MODDIV_ERR_EN
            check("err_vs_model", int'(err), exp_err);
`endif
        end
    end

    task automatic run_op(input int x, input int y, input int hold, output int res, output int cyc);
        exp_r = model(x, y);
        exp_err = (y == 0 || x >= P || y >= P) ? 1 : 0;
        check("in_ready_idle", int'(in_ready), 1);
        a = DW'(x);
        b = DW'(y);
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        cyc = 1;
        while (!out_valid && cyc < 60) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) check("timeout", 0, 1);
        res = int'(r);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check("handoff_out_valid", int'(out_valid), 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_r", int'(r), 0);
        rst_n = 1;

        run_op(1, 2, 0, got, lat);
        check("1/2", got, 126);
        check("1/2_lat", int'(lat <= 34), 1);
        run_op(3, 5, 0, got, lat);
        check("3/5", got, 101);
        run_op(250, 250, 0, got, lat);
        check("250/250", got, 1);
        run_op(77, 1, 0, got, lat);
        check("77/1", got, 77);
        check("77/1_lat", lat, 2);
        run_op(9, 0, 0, got, lat);
        check("9/0", got, 0);
        check("9/0_lat", lat, 1);
        run_op(0, 7, 0, got, lat);
        check("0/7", got, 0);

        // Stall the consumer: compare process checks r and in_ready each held cycle.
        run_op(1, 2, 10, got, lat);
        check("1/2_held", got, 126);

`ifdef MODDIV_ERR_EN
        run_op(5, 251, 0, got, lat);
        check("b_ge_p_r", got, 0);
        check("b_ge_p_lat", lat, 1);
        run_op(251, 3, 0, got, lat);
        check("a_ge_p_r", got, 0);
`endif

        // Reset mid-iteration aborts the operation.
        a = 3;
        b = 7;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (3) @(posedge clk);
        #1;
        check("mid_iter_busy", int'(in_ready), 0);
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        check("abort_in_ready", int'(in_ready), 1);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_r", int'(r), 0);
        run_op(3, 5, 0, got, lat);
        check("3/5_after_rst", got, 101);

        for (int i = 0; i < 1500; i++) begin
            run_op(int'($urandom_range(0, P - 1)), int'($urandom_range(1, P - 1)), 0, got, lat);
            check("rand_lat_bound", int'(lat <= LAT_MAX), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
